lsu_core: RTL and testbench
===========================

# lsu_core

Parametrised load/store unit for the MEM stage, replacing the single-cycle fixed-64-bit memory access path. It accepts one load or store per handshake from the EX/MEM register and talks to data memory over a request/grant/response bus with arbitrary wait states. Writes use byte strobes instead of read-modify-write, loads are lane-extracted and sign/zero-extended, and misaligned or illegal-width accesses are flagged instead of issued. The pipeline stalls through `req_ready_o` while an access is outstanding.

## Interface
- `XLEN`, 64: data width, 32 or 64; memory bus width equals `XLEN`.
- `ADDR_W`, 64: address width.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: MEM-stage access request.
- `req_ready_o` out 1: unit can accept; low means stall.
- `is_load_i` in 1: request is a load.
- `is_store_i` in 1: request is a store (exclusive with load).
- `funct3_i` in 3: RISC-V funct3 (LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110; SB..SD=000..011).
- `addr_i` in ADDR_W: byte address.
- `wdata_i` in XLEN: store data, LSB-aligned.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rdata_o` out XLEN: extended load result, held until next completion.
- `err_o` out 1: with `rsp_valid_o`, access was misaligned or illegal.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: write request.
- `mem_addr_o` out ADDR_W: lane-aligned address (low log2(XLEN/8) bits zero).
- `mem_wdata_o` out XLEN: store data shifted to its lanes.
- `mem_wstrb_o` out XLEN/8: byte write strobes.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: response (load data or write ack).
- `mem_rdata_i` in XLEN: full-lane read data.

## Operation
- Handshake: transfer when `req_valid_i && req_ready_o`; request fields are registered at transfer.
- `req_ready_o` = 1 only in IDLE.
- FSM states: IDLE, REQ, WAIT, ERR.
  - IDLE → REQ on a legal transfer; IDLE → ERR on an illegal one.
  - REQ: `mem_req_o`=1, bus fields stable; REQ → WAIT on `mem_gnt_i`.
  - WAIT: `mem_req_o`=0; WAIT → IDLE on `mem_rvalid_i`, and the response is registered.
  - ERR → IDLE unconditionally, pulsing `rsp_valid_o` with `err_o`=1.
- Illegal access, meaning no memory request is issued:
  - address not aligned to the access size (half: bit0; word: bits1:0; double: bits2:0);
  - funct3 011/110 when `XLEN`=32;
  - funct3 ≥ 111 for loads, or funct3 ≥ 100 for stores.
- Store:
  - strobe = size mask << addr offset;
  - `mem_wdata_o` = `wdata_i` << (8×offset);
  - `mem_rvalid_i` acknowledges the write;
  - `rdata_o` is unchanged.
- Load:
  - byte/half/word lane selected by offset from `mem_rdata_i`, then sign- or zero-extended to `XLEN`;
  - `mem_wstrb_o` = 0.
- `mem_rvalid_i` outside WAIT is ignored.

## Timing
- Reset values:
  - all outputs 0, except `req_ready_o`=1;
  - `rdata_o`=0;
  - state IDLE.
- Best-case latency, with grant in the first REQ cycle and rvalid the next cycle:
  - transfer at cycle 0, `mem_req_o` at cycle 1, `mem_rvalid_i` at cycle 2;
  - `rsp_valid_o`/`rdata_o` registered, visible at cycle 3;
  - `req_ready_o` is high again at cycle 3.
- Illegal access: `rsp_valid_o`+`err_o` at cycle 1; `req_ready_o` high at cycle 2.
- Grant and rvalid in the same cycle while in REQ: complete directly (REQ → IDLE).
- Reset mid-access aborts to IDLE. The memory side must tolerate the dropped transaction, and a late `mem_rvalid_i` is ignored.
- Throughput: at most one outstanding access; no pipelining of requests.

## Structure
- Shared constants in `define.v`:
  - funct3 codes `lb`..`lwu` and `sb`..`sd` as listed;
  - FSM state encoding (2 bits).
- Sub-module `lsu_align`:
  - purely combinational;
  - store shift/strobe generation;
  - load lane extract and extend;
  - alignment/legality check;
  - parametrised by `XLEN`.
- `lsu_core` holds the FSM, request registers and response register.

## Test plan
- XLEN=64, SB addr 0x1003 data 0xAB:
  - `mem_addr_o`=0x1000, `mem_wstrb_o`=0x08, `mem_wdata_o`[31:24]=0xAB;
  - completes after rvalid with `err_o`=0.
- LB addr 0x1005, `mem_rdata_i`=0x0000_8000_0000_0000 → `rdata_o`=0xFFFF_FFFF_FFFF_FF80. Same data with LBU → 0x80.
- LW addr 0x1002 → no `mem_req_o`, `rsp_valid_o`=`err_o`=1 at cycle 1.
- XLEN=32, LD (011) addr 0x0 → `err_o`=1.
- `mem_gnt_i` delayed 3 cycles → `mem_req_o`, `mem_addr_o`, `mem_wdata_o` stable throughout, and `req_ready_o`=0 until completion.
- Assert `rst_n_i` low in WAIT, release, then drive a stray `mem_rvalid_i` → state IDLE, outputs at reset values, no `rsp_valid_o`.

Source files
------------

// File: rtl/lsu_core_pkg.sv
// Shared funct3 codes, FSM state encoding and helpers for the load/store unit.
package lsu_core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } lsu_state_e;

    // Byte-enable pattern for an access of 2**size bytes, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return 8'h01;
            F3_SH:   return 8'h03;
            F3_SW:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store shift/strobes, load extract/extend.
module lsu_align
    import lsu_core_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    localparam int OFF_W  = $clog2(XLEN / 8),
    localparam int STRB_W = XLEN / 8
) (
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [2:0]        rsp_funct3,
    input  logic [OFF_W-1:0]  rsp_off,
    input  logic [XLEN-1:0]   rdata,
    output logic              legal,
    output logic [ADDR_W-1:0] lane_addr,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   rdata_ext
);

    logic [OFF_W-1:0] off;
    logic             misalign;
    logic             bad_code;
    logic             bad_xlen;
    logic [XLEN-1:0]  sh;

    assign off = addr[OFF_W-1:0];

    always_comb begin
        case (funct3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            2'b11:   misalign = |addr[2:0];
            default: misalign = 1'b0;
        endcase
        if (is_store)
            bad_code = funct3 > F3_SD;
        else if (is_load)
            bad_code = funct3 == 3'b111;
        else
            bad_code = 1'b1;
        // Doubleword and LWU have no meaning on a 32-bit datapath.
        bad_xlen = (XLEN == 32) && (funct3 == F3_LD || funct3 == F3_LWU);
        legal    = !(misalign || bad_code || bad_xlen);
    end

    assign lane_addr = addr & ~ADDR_W'(STRB_W - 1);
    assign wdata_sh  = wdata << {off, 3'b000};
    assign wstrb     = is_store ? (STRB_W'(size_mask(funct3)) << off) : '0;

    assign sh = rdata >> {rsp_off, 3'b000};

    always_comb begin
        case (rsp_funct3)
            F3_LB:   rdata_ext = XLEN'($signed(sh[7:0]));
            F3_LBU:  rdata_ext = XLEN'(sh[7:0]);
            F3_LH:   rdata_ext = XLEN'($signed(sh[15:0]));
            F3_LHU:  rdata_ext = XLEN'(sh[15:0]);
            F3_LW:   rdata_ext = XLEN'($signed(sh[31:0]));
            F3_LWU:  rdata_ext = XLEN'(sh[31:0]);
            default: rdata_ext = sh;
        endcase
    end

endmodule

// File: rtl/lsu_core.sv
// MEM-stage load/store unit: one outstanding access over a req/gnt/rvalid bus.
module lsu_core
    import lsu_core_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [2:0]          funct3_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                rsp_valid_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN/8-1:0]   mem_wstrb_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    localparam int OFF_W = $clog2(XLEN / 8);

    lsu_state_e          state;
    logic                ld_q;
    logic [2:0]          f3_q;
    logic [OFF_W-1:0]    off_q;
    logic                legal;
    logic                done;
    logic [ADDR_W-1:0]   lane_addr;
    logic [XLEN-1:0]     wdata_sh;
    logic [XLEN/8-1:0]   wstrb;
    logic [XLEN-1:0]     rdata_ext;

    // Request side works on the live inputs; response side on the registered request.
    lsu_align #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_align (
        .is_load    (is_load_i),
        .is_store   (is_store_i),
        .funct3     (funct3_i),
        .addr       (addr_i),
        .wdata      (wdata_i),
        .rsp_funct3 (f3_q),
        .rsp_off    (off_q),
        .rdata      (mem_rdata_i),
        .legal      (legal),
        .lane_addr  (lane_addr),
        .wdata_sh   (wdata_sh),
        .wstrb      (wstrb),
        .rdata_ext  (rdata_ext)
    );

    assign done = mem_rvalid_i &&
                  ((state == S_WAIT) || (state == S_REQ && mem_gnt_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            ld_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        ld_q        <= is_load_i;
                        f3_q        <= funct3_i;
                        off_q       <= addr_i[OFF_W-1:0];
                        if (legal) begin
                            state       <= S_REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store_i;
                            mem_addr_o  <= lane_addr;
                            mem_wdata_o <= is_store_i ? wdata_sh : '0;
                            mem_wstrb_o <= wstrb;
                        end else begin
                            state       <= S_ERR;
                            rsp_valid_o <= 1'b1;
                            err_o       <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: ;
                S_ERR: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    err_o       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
            // Completion overrides the REQ->WAIT step when gnt and rvalid coincide.
            if (done) begin
                state       <= S_IDLE;
                req_ready_o <= 1'b1;
                rsp_valid_o <= 1'b1;
                err_o       <= 1'b0;
                if (ld_q)
                    rdata_o <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_core.sv
// Randomized bench for lsu_core against a byte-arithmetic model, plus an XLEN=32 instance.
module tb_lsu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        req_valid = 0, req_ready, is_load = 0, is_store = 0;
    logic [2:0]  funct3 = 0;
    logic [63:0] addr = 0, wdata = 0, rdata;
    logic        rsp_valid, err, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [63:0] mem_rdata = 0;

    logic        q_valid = 0, q_ready, q_ld = 0, q_st = 0;
    logic [2:0]  q_f3 = 0;
    logic [63:0] q_addr = 0, q_maddr;
    logic [31:0] q_wdata = 0, q_rdata, q_mwdata, q_mrdata = 0;
    logic        q_rsp, q_err, q_mreq, q_mwe;
    logic [3:0]  q_mstrb;
    logic        q_gnt = 0, q_rv = 0;

    lsu_core #(.XLEN(64), .ADDR_W(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr),
        .wdata_i(wdata), .rsp_valid_o(rsp_valid), .rdata_o(rdata), .err_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu_core #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(q_valid), .req_ready_o(q_ready),
        .is_load_i(q_ld), .is_store_i(q_st), .funct3_i(q_f3), .addr_i(q_addr),
        .wdata_i(q_wdata), .rsp_valid_o(q_rsp), .rdata_o(q_rdata), .err_o(q_err),
        .mem_req_o(q_mreq), .mem_we_o(q_mwe), .mem_addr_o(q_maddr),
        .mem_wdata_o(q_mwdata), .mem_wstrb_o(q_mstrb), .mem_gnt_i(q_gnt),
        .mem_rvalid_i(q_rv), .mem_rdata_i(q_mrdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    function automatic bit legal_m(input int xlen, input bit ld, input bit st,
                                   input logic [2:0] f3, input logic [63:0] a);
        int bytes = 1 << f3[1:0];
        if (ld == st) return 0;
        if (st && f3 > 3) return 0;
        if (ld && f3 == 7) return 0;
        if (xlen == 32 && (f3 == 3 || f3 == 6)) return 0;
        if (a % bytes != 0) return 0;
        return 1;
    endfunction

    function automatic logic [7:0] strb_m(input logic [2:0] f3, input logic [63:0] a);
        int bytes = 1 << f3[1:0];
        logic [15:0] s = ((16'd1 << bytes) - 16'd1) << (a % 8);
        return s[7:0];
    endfunction

    function automatic logic [63:0] wdata_m(input logic [63:0] wd, input logic [63:0] a);
        return wd << (8 * (a % 8));
    endfunction

    function automatic logic [63:0] load_m(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] rd);
        int bytes = 1 << f3[1:0];
        logic [63:0] v = rd >> (8 * (a % 8));
        logic [63:0] mask;
        if (bytes < 8) begin
            mask = (64'd1 << (8 * bytes)) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[8 * bytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---- expectations for the 64-bit instance, checked every cycle ----
    bit          chk_en = 0;
    bit          e_ready = 1, e_req = 0, e_rsp = 0, e_err = 0, e_we = 0;
    logic [63:0] e_rdata = 0, e_addr = 0, e_wdata = 0;
    logic [7:0]  e_strb = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("mem_req", 64'(mem_req), 64'(e_req));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("rdata", rdata, e_rdata);
            if (e_rsp) chk("err", 64'(err), 64'(e_err));
            if (e_req) begin
                chk("mem_we", 64'(mem_we), 64'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        is_load  = 1'($urandom);
        is_store = 1'($urandom);
        funct3   = 3'($urandom);
        addr     = {$urandom, $urandom};
        wdata    = {$urandom, $urandom};
    endtask

    task automatic txn(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rd,
                       input int gd, input int rvd, input bit same);
        bit ok = legal_m(64, ld, !ld, f3, a);
        req_valid = 1; is_load = ld; is_store = !ld; funct3 = f3; addr = a; wdata = wd;
        mem_gnt = 0; mem_rvalid = 0;
        e_ready = 1; e_req = 0; e_rsp = 0;
        step();
        req_valid = 0;
        scramble_req();
        e_ready = 0;
        if (!ok) begin
            e_rsp = 1; e_err = 1;
            step();
            e_rsp = 0; e_ready = 1;
            return;
        end
        e_req = 1; e_we = !ld; e_addr = a & ~64'h7;
        e_strb = ld ? 8'h00 : strb_m(f3, a);
        e_wdata = wdata_m(wd, a);
        for (int k = 0; k <= gd; k++) begin
            mem_gnt = (k == gd);
            if (k == gd && same) begin
                mem_rvalid = 1; mem_rdata = rd;
            end else begin
                mem_rvalid = (k != gd) && 1'($urandom);
                mem_rdata = {$urandom, $urandom};
            end
            step();
        end
        mem_gnt = 0; mem_rvalid = 0; e_req = 0;
        if (!same) begin
            for (int k = 0; k <= rvd; k++) begin
                mem_rvalid = (k == rvd);
                mem_gnt = 1'($urandom);
                mem_rdata = (k == rvd) ? rd : {$urandom, $urandom};
                step();
            end
        end
        mem_rvalid = 0; mem_gnt = 0; mem_rdata = {$urandom, $urandom};
        e_rsp = 1; e_err = 0; e_ready = 1;
        if (ld) e_rdata = load_m(f3, a, rd);
        step();
        e_rsp = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            mem_rvalid = 1'($urandom);
            mem_gnt = 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            step();
        end
        mem_rvalid = 0; mem_gnt = 0;
    endtask

    task automatic txn32(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                         input logic [31:0] rd, input bit exp_err, input logic [31:0] exp_rd,
                         input string nm);
        q_valid = 1; q_ld = ld; q_st = !ld; q_f3 = f3; q_addr = a;
        step();
        q_valid = 0;
        chk({nm, "_mreq"}, 64'(q_mreq), 64'(!exp_err));
        chk({nm, "_ready"}, 64'(q_ready), 64'd0);
        if (exp_err) begin
            chk({nm, "_rsp"}, 64'(q_rsp), 64'd1);
            chk({nm, "_err"}, 64'(q_err), 64'd1);
        end else begin
            chk({nm, "_maddr"}, q_maddr, a & ~64'h3);
            q_gnt = 1; q_rv = 1; q_mrdata = rd;
            step();
            q_gnt = 0; q_rv = 0;
            chk({nm, "_rsp"}, 64'(q_rsp), 64'd1);
            chk({nm, "_err"}, 64'(q_err), 64'd0);
            chk({nm, "_rdata"}, 64'(q_rdata), 64'(exp_rd));
        end
        step();
        chk({nm, "_ready2"}, 64'(q_ready), 64'd1);
        chk({nm, "_rsp2"}, 64'(q_rsp), 64'd0);
    endtask

    initial begin
        logic [63:0] tmp;
        #1 rst_n = 0;
        chk_en = 1;
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        step(); step();
        rst_n = 1;

        // Pin the model with hand-derived values.
        chk("pin_strb_sb", 64'(strb_m(3'b000, 64'h1003)), 64'h08);
        tmp = wdata_m(64'hAB, 64'h1003);
        chk("pin_wdata_sb", 64'(tmp[31:24]), 64'hAB);
        chk("pin_lb", load_m(3'b000, 64'h1005, 64'h0000_8000_0000_0000), 64'hFFFF_FFFF_FFFF_FF80);
        chk("pin_lbu", load_m(3'b100, 64'h1005, 64'h0000_8000_0000_0000), 64'h80);
        chk("pin_lw_mis", 64'(legal_m(64, 1, 0, 3'b010, 64'h1002)), 64'd0);
        chk("pin_ld32", 64'(legal_m(32, 1, 0, 3'b011, 64'h0)), 64'd0);

        // Directed cases.
        txn(0, 3'b000, 64'h1003, 64'hAB, 64'h0, 0, 0, 0);
        txn(1, 3'b000, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 0);
        txn(1, 3'b100, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 1, 2, 0);
        txn(1, 3'b010, 64'h1002, 64'h0, 64'h0, 0, 0, 0);
        txn(0, 3'b011, 64'h2008, 64'h1122_3344_5566_7788, 64'h0, 3, 1, 0);
        txn(1, 3'b011, 64'h2008, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 1);
        txn(1, 3'b111, 64'h2000, 64'h0, 64'h0, 0, 0, 0);
        txn(0, 3'b100, 64'h2000, 64'h0, 64'h0, 0, 0, 0);
        idle(2);

        // Reset while waiting for the response, then a stray rvalid.
        req_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b011; addr = 64'h3000;
        step();
        req_valid = 0;
        e_ready = 0; e_req = 1; e_we = 0; e_addr = 64'h3000; e_strb = 8'h00;
        mem_gnt = 1;
        step();
        mem_gnt = 0; e_req = 0;
        step();
        rst_n = 0;
        e_ready = 1; e_rdata = 0;
        step();
        rst_n = 1;
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rvalid = 0;
        step();

        // XLEN=32 instance.
        txn32(1, 3'b011, 64'h0, 32'h0, 1, 32'h0, "x32_ld");
        txn32(1, 3'b110, 64'h4, 32'h0, 1, 32'h0, "x32_lwu");
        txn32(1, 3'b010, 64'h6, 32'h0, 1, 32'h0, "x32_lw_mis");
        txn32(1, 3'b010, 64'h4, 32'h8000_0000, 0, 32'h8000_0000, "x32_lw");
        txn32(1, 3'b101, 64'h2, 32'h8001_2345, 0, 32'h0000_8001, "x32_lhu");
        txn32(1, 3'b001, 64'h2, 32'h8001_2345, 0, 32'hFFFF_8001, "x32_lh");

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            bit          ld = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [63:0] a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            txn(ld, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(3)), int'($urandom_range(2)), $urandom_range(3) == 0);
            idle(int'($urandom_range(2)));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
